// File: rtl/nv_ram_fifo_ctrl_256x64_if.sv
// nv_ram_fifo_ctrl_256x64_if: ready/valid bundle for the 256x64 RAM FIFO; hwm/hwm_clr exist only with FIFO_CTRL_HWM_EN
interface nv_ram_fifo_ctrl_256x64_if;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [63:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [63:0] rd_pd;
  logic        wr_afull;
  logic        fifo_idle;
  logic [31:0] pwrbus_ram_pd;
`ifdef FIFO_CTRL_HWM_EN
  logic [8:0]  hwm;
  logic        hwm_clr;
  modport master (
    output wr_pvld, wr_pd, rd_prdy, pwrbus_ram_pd, hwm_clr,
    input  wr_prdy, rd_pvld, rd_pd, wr_afull, fifo_idle, hwm
  );
  modport slave (
    input  wr_pvld, wr_pd, rd_prdy, pwrbus_ram_pd, hwm_clr,
    output wr_prdy, rd_pvld, rd_pd, wr_afull, fifo_idle, hwm
  );
`else
  modport master (
    output wr_pvld, wr_pd, rd_prdy, pwrbus_ram_pd,
    input  wr_prdy, rd_pvld, rd_pd, wr_afull, fifo_idle
  );
  modport slave (
    input  wr_pvld, wr_pd, rd_prdy, pwrbus_ram_pd,
    output wr_prdy, rd_pvld, rd_pd, wr_afull, fifo_idle
  );
`endif
endinterface

// File: rtl/nv_ram_fifo_ctrl_256x64.sv
// nv_ram_fifo_ctrl_256x64: 256x64 ready/valid FIFO over a 1R1W RAM with 3-entry output buffer; FIFO_CTRL_HWM_EN adds hwm
module nv_ram_rws_256x64 (
  input  logic        clk,
  input  logic [31:0] pwrbus_ram_pd,
  input  logic        re,
  input  logic        we,
  input  logic [7:0]  ra,
  input  logic [7:0]  wa,
  input  logic [63:0] di,
  output logic [63:0] dout
);
  logic [63:0] mem [256];
  logic [7:0]  ra_q;
  logic        unused_pwr;
  assign unused_pwr = ^pwrbus_ram_pd;
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= di;
    if (re) ra_q <= ra;
  end
  assign dout = mem[ra_q];
endmodule

module nv_ram_fifo_ctrl_256x64 #(
  parameter int AFULL_TH = 240
) (
  input logic                      clk,
  input logic                      rst,
  nv_ram_fifo_ctrl_256x64_if.slave io
);
  localparam int DEPTH = 256;
  localparam int WIDTH = 64;
  logic [7:0]                  wr_adr;
  logic [7:0]                  rd_adr;
  logic [8:0]                  cnt;
  logic [8:0]                  cnt_nxt;
  logic [8:0]                  ram_cnt;
  logic                        inflight;
  logic [1:0]                  obuf_cnt;
  logic [2:0][WIDTH-1:0]       obuf;
  logic [2:0][WIDTH-1:0]       obuf_nxt;
  logic [WIDTH-1:0]            dout;
  logic                        push;
  logic                        pop;
  logic                        re;
  assign push     = io.wr_pvld & io.wr_prdy;
  assign pop      = io.rd_pvld & io.rd_prdy;
  // issue only from registered state so rd_prdy never reaches the RAM enable
  assign re       = (ram_cnt != 9'd0) && (({1'b0, obuf_cnt} + {2'b0, inflight}) < 3'd3);
  assign cnt_nxt  = cnt + 9'(push) - 9'(pop);
  assign io.rd_pvld = obuf_cnt != 2'd0;
  assign io.rd_pd   = obuf[0];
  nv_ram_rws_256x64 u_ram (
    .clk           (clk),
    .pwrbus_ram_pd (io.pwrbus_ram_pd),
    .re            (re),
    .we            (push),
    .ra            (rd_adr),
    .wa            (wr_adr),
    .di            (io.wr_pd),
    .dout          (dout)
  );
  // head sits in slot 0; a pop shifts zeros in so empty slots read as 0
  always_comb begin
    obuf_nxt = pop ? {{WIDTH{1'b0}}, obuf[2:1]} : obuf;
    for (int i = 0; i < 3; i++)
      if (inflight && 2'(i) == obuf_cnt - 2'(pop)) obuf_nxt[i] = dout;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_adr       <= '0;
      rd_adr       <= '0;
      cnt          <= '0;
      ram_cnt      <= '0;
      inflight     <= 1'b0;
      obuf_cnt     <= '0;
      obuf         <= '0;
      io.wr_prdy   <= 1'b0;
      io.wr_afull  <= 1'b0;
      io.fifo_idle <= 1'b1;
    end else begin
      wr_adr       <= wr_adr + 8'(push);
      rd_adr       <= rd_adr + 8'(re);
      cnt          <= cnt_nxt;
      ram_cnt      <= ram_cnt + 9'(push) - 9'(re);
      inflight     <= re;
      obuf_cnt     <= obuf_cnt + 2'(inflight) - 2'(pop);
      obuf         <= obuf_nxt;
      io.wr_prdy   <= cnt_nxt != 9'(DEPTH);
      io.wr_afull  <= cnt_nxt >= 9'(AFULL_TH);
      io.fifo_idle <= cnt_nxt == 9'd0;
    end
  end
`ifdef FIFO_CTRL_HWM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) io.hwm <= '0;
    else io.hwm <= (io.hwm_clr || cnt_nxt > io.hwm) ? cnt_nxt : io.hwm;
  end
`endif
endmodule
